aes_round_ctrl: RTL

//  Iterative AES-128 encryption sequencer. Owns the 128b state and round-key registers.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_keyexpand_step.sv | 30 +++
 rtl/aes_transforms.sv | 54 +++++
 rtl/aes_round_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the round controller.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} ctrl_state_t;

  localparam logic [7:0] RCON0     = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo the AES polynomial; also advances rcon.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One MixColumns column: byte 0 of the column sits in bits [31:24].
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_keyexpand_step.sv
// Produces the next AES-128 round key from the current one and its rcon.
module aes_keyexpand_step
  import aes_pkg::*;
(
  input  block_t     rk,
  input  logic [7:0] rcon,
  output block_t     rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  // RotWord then SubWord on the last word, with rcon folded into the top byte.
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
                {rcon, 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_transforms.sv
// Combinational AES round transforms: SubBytes, ShiftRows and MixColumns.
// Byte i of a block lives at [127-8*i -: 8], row i%4, column i/4.
module aes_subbytes
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  // Substitute every byte through the S-box.
  always_comb begin
    dout = '0;
    for (int i = 0; i < 16; i++) begin
      dout[127-8*i -: 8] = sbox(din[127-8*i -: 8]);
    end
  end

endmodule

module aes_shiftrows
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  // Row r rotates left by r columns.
  always_comb begin
    dout = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
  end

endmodule

module aes_mixcolumns
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout
);

  // Mix each of the four 32-bit columns independently.
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      dout[127-32*c -: 32] = mix_col(din[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock, keys expanded on the fly.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NROUNDS = 10,
  localparam int RW = $clog2(NROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [127:0]  key,
  input  logic [127:0]  plaintext,
  output logic          ready,
  output logic          done,
  output logic [127:0]  ciphertext,
  output logic [RW-1:0] round_idx,
  output logic [127:0]  dbg_state
);

  ctrl_state_t fsm, fsm_next;
  block_t      state, state_next;
  block_t      rk, rk_load;
  block_t      ct_reg, ct_next;
  logic [7:0]  rcon, rcon_next;
  logic [RW-1:0] round, round_next;
  logic        done_reg, done_next;

  block_t sb_out, sr_out, mc_out, rk_step;

  aes_subbytes       u_subbytes  (.din(state),  .dout(sb_out));
  aes_shiftrows      u_shiftrows (.din(sb_out), .dout(sr_out));
  aes_mixcolumns     u_mixcols   (.din(sr_out), .dout(mc_out));
  aes_keyexpand_step u_keystep   (.rk(rk), .rcon(rcon), .rk_next(rk_step));

  // Register every piece of controller and datapath state; reset clears all of it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm    <= IDLE;
      state  <= '0;
      rk     <= '0;
      ct_reg <= '0;
      rcon   <= RCON0;
      round  <= '0;
      done_reg <= 1'b0;
    end else begin
      fsm    <= fsm_next;
      state  <= state_next;
      rk     <= rk_load;
      ct_reg <= ct_next;
      rcon   <= rcon_next;
      round  <= round_next;
      done_reg <= done_next;
    end
  end

  // Next-state logic: load on accepted start, full rounds, then a final round without MixColumns.
  always_comb begin
    fsm_next   = fsm;
    state_next = state;
    rk_load    = rk;
    ct_next    = ct_reg;
    rcon_next  = rcon;
    round_next = round;
    done_next  = 1'b0;
    case (fsm)
      IDLE, DONE: begin
        round_next = '0;
        if (start) begin
          state_next = plaintext ^ key;
          rk_load    = key;
          rcon_next  = RCON0;
          round_next = RW'(1);
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        state_next = mc_out ^ rk_step;
        rk_load    = rk_step;
        rcon_next  = xtime(rcon);
        round_next = round + RW'(1);
        if (round == RW'(NROUNDS - 1)) fsm_next = FINAL;
      end
      FINAL: begin
        state_next = sr_out ^ rk_step;
        rk_load    = rk_step;
        ct_next    = sr_out ^ rk_step;
        done_next  = 1'b1;
        round_next = '0;
        fsm_next   = DONE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign ready      = (fsm == IDLE) || (fsm == DONE);
  assign done       = done_reg;
  assign ciphertext = ct_reg;
  assign round_idx  = round;
  assign dbg_state  = state;

endmodule
